// File: rtl/lut_cfg_pkg.sv
// rtl/lut_cfg_pkg.sv - shared state encoding and width helpers for the LUT configuration loader
package lut_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        COMMIT = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int words_per_lut(input int mem_size, input int config_width);
        return mem_size / config_width;
    endfunction

    function automatic int idx_width(input int num_luts);
        return (num_luts <= 1) ? 1 : $clog2(num_luts);
    endfunction

    function automatic int wcnt_width(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

    // A frame must split into a whole number of input words
    function automatic bit frame_fits(input int mem_size, input int config_width);
        return (config_width > 0) && (mem_size % config_width == 0) && (mem_size >= config_width);
    endfunction

endpackage

// File: rtl/lut_cfg_assembler.sv
// rtl/lut_cfg_assembler.sv - word counter and frame assembly register, LSB word first
module lut_cfg_assembler
    import lut_cfg_pkg::*;
#(
    parameter int MEM_SIZE      = 16,
    parameter int CONFIG_WIDTH  = 8,
    parameter int WORDS_PER_LUT = 2,
    parameter int WCNT_W        = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    accept,
    input  logic [CONFIG_WIDTH-1:0] data,
    output logic                    last,
    output logic [MEM_SIZE-1:0]     frame
);

    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [MEM_SIZE-1:0] frame_q, frame_d;

    assign last = (word_cnt_q == WCNT_W'(WORDS_PER_LUT - 1));

    // The frame output already contains the word being accepted this cycle,
    // so the caller can latch a complete frame on the same edge as the last word.
    assign frame = frame_d;

    // Merge the accepted word into its slot and advance / wrap the word counter
    always_comb begin
        word_cnt_d = word_cnt_q;
        frame_d    = frame_q;
        if (clr) begin
            word_cnt_d = '0;
        end else if (accept) begin
            for (int k = 0; k < WORDS_PER_LUT; k++) begin
                if (word_cnt_q == WCNT_W'(k)) begin
                    frame_d[k*CONFIG_WIDTH +: CONFIG_WIDTH] = data;
                end
            end
            word_cnt_d = last ? '0 : word_cnt_q + 1'b1;
        end
    end

    // Assembly state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            frame_q    <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            frame_q    <= frame_d;
        end
    end

endmodule

// File: rtl/lut_config_loader.sv
// rtl/lut_config_loader.sv - bank LUT configuration sequencer; optional trailer checksum via LUT_CFG_CHECKSUM_EN
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2**INPUTS,
    parameter int CONFIG_WIDTH = 8,
    parameter int NUM_LUTS     = 4
) (
    input  logic                    cclk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    cfg_valid,
    input  logic [CONFIG_WIDTH-1:0] cfg_data,
    output logic                    cfg_ready,
    output logic [MEM_SIZE-1:0]     config_out,
    output logic [NUM_LUTS-1:0]     cen,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int WORDS_PER_LUT = words_per_lut(MEM_SIZE, CONFIG_WIDTH);
    localparam int IDX_W         = idx_width(NUM_LUTS);
    localparam int WCNT_W        = wcnt_width(WORDS_PER_LUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

    if (!frame_fits(MEM_SIZE, CONFIG_WIDTH) || MEM_SIZE != 2**INPUTS || NUM_LUTS < 1) begin : g_bad_params
        $error("lut_config_loader: illegal MEM_SIZE/CONFIG_WIDTH/NUM_LUTS combination");
    end

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    lut_idx_q, lut_idx_d;
    logic [MEM_SIZE-1:0] config_out_q, config_out_d;
    logic [NUM_LUTS-1:0] cen_q, cen_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;
    logic                asm_clr;
    logic                asm_last;
    logic [MEM_SIZE-1:0] asm_frame;

`ifdef LUT_CFG_CHECKSUM_EN
    logic [CONFIG_WIDTH-1:0] csum_q, csum_d;
    logic                    err_q, err_d;
`endif

    // cfg_ready is a registered, state-only signal, so acceptance never loops back into the source
    assign accept = cfg_valid & cfg_ready_q;

    lut_cfg_assembler #(
        .MEM_SIZE      (MEM_SIZE),
        .CONFIG_WIDTH  (CONFIG_WIDTH),
        .WORDS_PER_LUT (WORDS_PER_LUT),
        .WCNT_W        (WCNT_W)
    ) u_assembler (
        .clk    (cclk),
        .rst_n  (rst_n),
        .clr    (asm_clr),
        .accept (accept && state_q == LOAD),
        .data   (cfg_data),
        .last   (asm_last),
        .frame  (asm_frame)
    );

    // Next-state, LUT index, frame bus and registered-output decode
    always_comb begin
        state_d      = state_q;
        lut_idx_d    = lut_idx_q;
        config_out_d = config_out_q;
        asm_clr      = 1'b0;
`ifdef LUT_CFG_CHECKSUM_EN
        csum_d       = csum_q;
        err_d        = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    lut_idx_d = '0;
                    asm_clr   = 1'b1;
`ifdef LUT_CFG_CHECKSUM_EN
                    csum_d    = '0;
                    err_d     = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (accept) begin
`ifdef LUT_CFG_CHECKSUM_EN
                    csum_d = csum_q ^ cfg_data;
`endif
                    if (asm_last) begin
                        state_d      = COMMIT;
                        config_out_d = asm_frame;
                    end
                end
            end
            COMMIT: begin
                if (lut_idx_q == LAST_IDX) begin
`ifdef LUT_CFG_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    lut_idx_d = lut_idx_q + 1'b1;
                    state_d   = LOAD;
                end
            end
`ifdef LUT_CFG_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (cfg_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cfg_ready_d = (state_d == LOAD) || (state_d == CHECK);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        for (int i = 0; i < NUM_LUTS; i++) begin
            cen_d[i] = (state_d == COMMIT) && (lut_idx_d == IDX_W'(i));
        end
    end

    // FSM and registered outputs; reset aborts a load with cen dropped at once
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lut_idx_q    <= '0;
            config_out_q <= '0;
            cen_q        <= '0;
            cfg_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lut_idx_q    <= lut_idx_d;
            config_out_q <= config_out_d;
            cen_q        <= cen_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef LUT_CFG_CHECKSUM_EN
    // Running XOR of accepted data words and the sticky trailer mismatch flag
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cfg_ready  = cfg_ready_q;
    assign config_out = config_out_q;
    assign cen        = cen_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
